// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the serial nibble adder:
//     NIBBLE_W - width of the nibble datapath (4 bits)
//     state_t  - controller state encoding (IDLE/RUN/DONE; 2'd3 is unused
//                and recovers to IDLE)
package serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Adder_4bit.sv
// Full_Adder_4bit
//   Combinational 4-bit ripple-carry adder used as the shared nibble
//   datapath of serial_nibble_adder.
//   Ports:
//     a, b  in  [3:0]  nibble operands
//     cin   in         carry into bit 0
//     sum   out [3:0]  nibble sum
//     cout  out        carry out of bit 3
module Full_Adder_4bit
    import serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder
//   Multi-cycle WIDTH-bit adder. Accepts an operand pair on a valid/ready
//   handshake, adds one nibble per clock (LSB nibble first) through a single
//   Full_Adder_4bit, then holds {cout, sum} = a + b + cin on an output
//   valid/ready handshake.
//
//   Handshake semantics (both sides): a transfer happens on a rising clk
//   edge where valid and ready are both 1. in_ready is 1 only in IDLE,
//   out_valid is 1 only in DONE; in_valid/out_ready are ignored elsewhere.
//
//   Optional feature: define SERIAL_ADDER_OVF_EN to add the 'ovf' port
//   (signed overflow, registered together with cout).
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operand handshake
//     a, b [WIDTH-1:0]    operands, cin carry into nibble 0
//     out_valid/out_ready result handshake
//     sum [WIDTH-1:0]     registered sum, cout registered carry-out
//     ovf                 signed overflow (SERIAL_ADDER_OVF_EN only)
//
//   The controller state is held in 'state' (type state_t) so checkers can
//   bind to it directly.
module serial_nibble_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             carry_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                nib_cin;
    logic [CNT_W+1:0]    bit_idx;

    // Operand registers shift right each RUN cycle, so the current nibble
    // is always in the low 4 bits and no indexed read mux is needed.
    assign nib_cin = (count == '0) ? cin_q : carry_q;
    assign bit_idx = {count, 2'b00};

    Full_Adder_4bit u_nibble (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (nib_cin),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            count       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        cin_q      <= cin;
                        carry_q    <= 1'b0;
                        sum_q      <= '0;
                        count      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q[bit_idx +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_cout;
                    a_q     <= a_q >> NIBBLE_W;
                    b_q     <= b_q >> NIBBLE_W;
                    if (count == LAST) begin
                        cout_q      <= nib_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the last nibble a_q[3]/b_q[3] are the operand
                        // MSBs and nib_sum[3] is the sum MSB.
                        ovf_q <= (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                                 (nib_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb_serial_nibble_adder
//   Self-checking bench for serial_nibble_adder (WIDTH=16). Expected results
//   come from plain integer addition of the operands. Define
//   SERIAL_ADDER_OVF_EN to also exercise the ovf port.
module tb_serial_nibble_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH:0] exp_q[$];

    serial_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             c);
        int unsigned total;
        total = int'(x) + int'(y) + int'(c);
        return (WIDTH+1)'(total);
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge right after the accept edge; counts clock edges
    // until out_valid is seen. Expired bound counts as a failure.
    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    // One complete transaction: offer operands, wait for result, stall the
    // consumer for 'stall' cycles, sample outputs, then complete the output
    // handshake.
    task automatic do_txn(input  logic [WIDTH-1:0] ta,
                          input  logic [WIDTH-1:0] tbv,
                          input  logic             tc,
                          input  int               stall,
                          output logic [WIDTH-1:0] rs,
                          output logic             rc,
                          output logic             ro,
                          output int               lat);
        int n;
        @(negedge clk);
        a         = ta;
        b         = tbv;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        wait_out_valid(lat);
        repeat (stall) @(negedge clk);
        rs = sum;
        rc = cout;
`ifdef SERIAL_ADDER_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        tests_run++;
        if (sum !== '0) begin tests_failed++; $display("FAIL reset_sum: got %h required 0000", sum); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout: got %0b required 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b required 0", ovf); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] rs;
        logic             rc, ro;
        int               lat;
        do_txn(16'h00FF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
        // out_valid rises after edge E0+NIBBLES (accept cycle included: NIBBLES+1 cycles)
        tests_run++;
        if (lat !== NIBBLES) begin tests_failed++; $display("FAIL basic_latency: got %0d edges required %0d", lat, NIBBLES); end
        tests_run++;
        if (rs !== 16'h0100) begin tests_failed++; $display("FAIL basic_sum: got %h required 0100", rs); end
        tests_run++;
        if (rc !== 1'b0) begin tests_failed++; $display("FAIL basic_cout: got %0b required 0", rc); end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_after_handshake: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        logic [WIDTH-1:0] rs;
        logic             rc, ro;
        int               lat;
        do_txn(16'hFFFF, 16'h0000, 1'b1, 1, rs, rc, ro, lat);
        tests_run++;
        if (rs !== 16'h0000) begin tests_failed++; $display("FAIL ripple_sum: got %h required 0000", rs); end
        tests_run++;
        if (rc !== 1'b1) begin tests_failed++; $display("FAIL ripple_cout: got %0b required 1", rc); end
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_valid(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (sum !== 16'h5555 || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                bad++;
                $display("FAIL stall_hold[%0d]: sum=%h cout=%0b out_valid=%0b in_ready=%0b required 5555/0/1/0",
                         i, sum, cout, out_valid, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a2, b2;
        logic [WIDTH:0]   e2;
        int               lat;
        a2 = WIDTH'($urandom);
        b2 = WIDTH'($urandom);
        e2 = model_add(a2, b2, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // second pair offered continuously while the first is in flight
        a = a2; b = b2;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_in_ready: got %0b required 0", in_ready); end
        wait_out_valid(lat);
        tests_run++;
        if (sum !== 16'hFFFF || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first_result: sum=%h cout=%0b required ffff/0", sum, cout);
        end
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_in_ready: got %0b required 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_after_handshake: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_accept: in_ready=%0b required 0", in_ready); end
        wait_out_valid(lat);
        tests_run++;
        if (lat !== NIBBLES) begin tests_failed++; $display("FAIL b2b_latency: got %0d required %0d", lat, NIBBLES); end
        tests_run++;
        if ({cout, sum} !== e2) begin
            tests_failed++;
            $display("FAIL b2b_second_result: got %h required %h", {cout, sum}, e2);
        end
        // out_ready still high: DONE lasts exactly one cycle
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_single_done: out_valid=%0b required 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] rs;
        logic             rc, ro;
        int               lat;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (sum !== 16'h0022) begin tests_failed++; $display("FAIL midrun_partial: got %h required 0022", sum); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || sum !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_reset: out_valid=%0b sum=%h in_ready=%0b required 0/0000/1", out_valid, sum, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(16'h0001, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
        tests_run++;
        if (rs !== 16'h0002 || rc !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_next_txn: sum=%h cout=%0b required 0002/0", rs, rc);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ta, tbv, rs;
        logic             tc, rc, ro;
        logic [WIDTH:0]   e;
        int               lat;
        logic             eo;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       ta = 16'hFFFF;
                1:       ta = 16'h8000;
                default: ta = WIDTH'($urandom);
            endcase
            tbv = WIDTH'($urandom);
            tc  = 1'($urandom);
            exp_q.push_back(model_add(ta, tbv, tc));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn(ta, tbv, tc, $urandom_range(0, 3), rs, rc, ro, lat);
            e  = exp_q.pop_front();
            eo = model_ovf(ta, tbv, e[WIDTH-1:0]);
            tests_run++;
            if ({rc, rs} !== e) begin
                tests_failed++;
                $display("FAIL random_result[%0d]: a=%h b=%h cin=%0b got %h required %h", i, ta, tbv, tc, {rc, rs}, e);
            end
            tests_run++;
            if (lat !== NIBBLES) begin
                tests_failed++;
                $display("FAIL random_latency[%0d]: got %0d required %0d", i, lat, NIBBLES);
            end
`ifdef SERIAL_ADDER_OVF_EN
            tests_run++;
            if (ro !== eo) begin
                tests_failed++;
                $display("FAIL random_ovf[%0d]: got %0b required %0b", i, ro, eo);
            end
`else
            if (ro !== 1'b0 && eo === 1'bx) $display("unreachable");
`endif
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] rs;
        logic             rc, ro;
        int               lat;
        do_txn(16'h7FFF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
        tests_run++;
        if (rs !== 16'h8000 || ro !== 1'b1 || rc !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_pos: sum=%h ovf=%0b cout=%0b required 8000/1/0", rs, ro, rc);
        end
        do_txn(16'hFFFF, 16'h0001, 1'b0, 0, rs, rc, ro, lat);
        tests_run++;
        if (rs !== 16'h0000 || ro !== 1'b0 || rc !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_neg: sum=%h ovf=%0b cout=%0b required 0000/0/1", rs, ro, rc);
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_carry_ripple();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
